pc_predict: RTL and testbench

- Next-generation program counter unit with a parametrised direct-mapped branch target buffer (BTB) and 2-bit saturating direction predictors.
- Predicts the next fetch address each cycle from the current PC.
- Accepts resolved branch/jump outcomes from the execute stage, trains the BTB, and issues a redirect plus flush on misprediction.
- Sits between the instruction cache request path and the IF/ID latch; replaces the non-predicting PC block.

---
 rtl/cpu_types_pkg.sv | 25 ++
 rtl/branch_target_buffer.sv | 86 ++++++++
 rtl/pc_predict.sv | 100 ++++++++++
 tb/tb_pc_predict.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: fetch word size and the 2-bit branch direction counter
// with its saturating step helpers.
package cpu_types_pkg;

  // Bytes per instruction word; the sequential fetch stride.
  localparam int WBYTES = 4;

  typedef enum logic [1:0] {
    STRONG_NT = 2'b00,
    WEAK_NT   = 2'b01,
    WEAK_T    = 2'b10,
    STRONG_T  = 2'b11
  } btb_cnt_t;

  // Move one step toward strongly-taken, sticking at the top.
  function automatic btb_cnt_t cnt_inc(input btb_cnt_t c);
    return (c == STRONG_T) ? STRONG_T : btb_cnt_t'(c + 2'd1);
  endfunction

  // Move one step toward strongly-not-taken, sticking at the bottom.
  function automatic btb_cnt_t cnt_dec(input btb_cnt_t c);
    return (c == STRONG_NT) ? STRONG_NT : btb_cnt_t'(c - 2'd1);
  endfunction

endpackage

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer. One read port looks up the fetch PC;
// one update port trains the entry addressed by the resolved branch PC.
// Reads see pre-edge contents, so a same-index update is visible next cycle.
module branch_target_buffer
  import cpu_types_pkg::*;
#(
  parameter int          WORD_W      = 32,
  parameter int          BTB_ENTRIES = 16,
  parameter logic [1:0]  CNT_INIT    = 2'b10
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [WORD_W-1:0] i_rd_pc,
  output logic              o_rd_taken,
  output logic [WORD_W-1:0] o_rd_target,
  input  logic              i_wr_en,
  input  logic [WORD_W-1:0] i_wr_pc,
  input  logic              i_wr_taken,
  input  logic [WORD_W-1:0] i_wr_target
);

  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = WORD_W - IDX_W - 2;

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [WORD_W-1:0] target;
    btb_cnt_t          cnt;
  } entry_t;

  entry_t r_btb [BTB_ENTRIES];

  logic [IDX_W-1:0] w_rd_idx;
  logic [TAG_W-1:0] w_rd_tag;
  entry_t           w_rd_entry;
  logic             w_rd_hit;
  logic [IDX_W-1:0] w_wr_idx;
  logic [TAG_W-1:0] w_wr_tag;
  entry_t           w_wr_entry;
  logic             w_wr_hit;
  logic             w_unused_lsbs;

  // Byte-offset bits never select an entry; named so lint treats them as intentional.
  assign w_unused_lsbs = ^{i_rd_pc[1:0], i_wr_pc[1:0]};

  assign w_rd_idx    = i_rd_pc[IDX_W+1:2];
  assign w_rd_tag    = i_rd_pc[WORD_W-1:IDX_W+2];
  assign w_rd_entry  = r_btb[w_rd_idx];
  assign w_rd_hit    = w_rd_entry.valid && (w_rd_entry.tag == w_rd_tag);
  assign o_rd_taken  = w_rd_hit && w_rd_entry.cnt[1];
  assign o_rd_target = w_rd_entry.target;

  assign w_wr_idx   = i_wr_pc[IDX_W+1:2];
  assign w_wr_tag   = i_wr_pc[WORD_W-1:IDX_W+2];
  assign w_wr_entry = r_btb[w_wr_idx];
  assign w_wr_hit   = w_wr_entry.valid && (w_wr_entry.tag == w_wr_tag);

  // Train the entry at the resolved PC: bump/decay on a hit, allocate on a taken miss.
  always_ff @(posedge CLK) begin
    if (RST) begin
      // NOTE: only valid and cnt are cleared; tag and target are dead while
      // valid=0, so leaving them unreset lets the array map to plain RAM.
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        r_btb[i].valid <= 1'b0;
        r_btb[i].cnt   <= WEAK_NT;
      end
    end else if (i_wr_en) begin
      // NOTE: non-blocking so the read port keeps seeing pre-edge contents.
      if (w_wr_hit) begin
        if (i_wr_taken) begin
          r_btb[w_wr_idx].cnt    <= cnt_inc(w_wr_entry.cnt);
          r_btb[w_wr_idx].target <= i_wr_target;
        end else begin
          r_btb[w_wr_idx].cnt    <= cnt_dec(w_wr_entry.cnt);
        end
      end else if (i_wr_taken) begin
        r_btb[w_wr_idx].valid  <= 1'b1;
        r_btb[w_wr_idx].tag    <= w_wr_tag;
        r_btb[w_wr_idx].target <= i_wr_target;
        r_btb[w_wr_idx].cnt    <= btb_cnt_t'(CNT_INIT);
      end
    end
  end

endmodule

// File: rtl/pc_predict.sv
// Predicting program counter: holds the fetch PC, chooses the next fetch
// address from the BTB prediction, redirects and flushes on a resolved
// misprediction, and counts mispredictions.
module pc_predict
  import cpu_types_pkg::*;
#(
  parameter int                 WORD_W      = 32,
  parameter int                 BTB_ENTRIES = 16,
  parameter logic [WORD_W-1:0]  RESET_PC    = '0,
  parameter logic [1:0]         CNT_INIT    = 2'b10
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ihit,
  input  logic              halt,
  input  logic              ex_valid,
  input  logic [WORD_W-1:0] ex_pc,
  input  logic              ex_taken,
  input  logic [WORD_W-1:0] ex_target,
  input  logic              ex_pred_taken,
  input  logic [WORD_W-1:0] ex_pred_target,
  output logic [WORD_W-1:0] cpc,
  output logic [WORD_W-1:0] pc_plus,
  output logic              pred_taken,
  output logic [WORD_W-1:0] pred_target,
  output logic              flush,
  output logic [31:0]       mispred_cnt
);

  localparam logic [WORD_W-1:0] STEP = WORD_W'(WBYTES);

  logic [WORD_W-1:0] r_cpc;
  logic [31:0]       r_mispred_cnt;
  logic              w_btb_taken;
  logic [WORD_W-1:0] w_btb_target;
  logic              w_mis;
  logic [WORD_W-1:0] w_redirect_pc;
  logic [WORD_W-1:0] w_next_pc;

  branch_target_buffer #(
    .WORD_W      (WORD_W),
    .BTB_ENTRIES (BTB_ENTRIES),
    .CNT_INIT    (CNT_INIT)
  ) u_btb (
    .CLK         (CLK),
    .RST         (RST),
    .i_rd_pc     (r_cpc),
    .o_rd_taken  (w_btb_taken),
    .o_rd_target (w_btb_target),
    .i_wr_en     (ex_valid),
    .i_wr_pc     (ex_pc),
    .i_wr_taken  (ex_taken),
    .i_wr_target (ex_target)
  );

  assign cpc         = r_cpc;
  assign pc_plus     = r_cpc + STEP;
  assign pred_taken  = w_btb_taken;
  assign pred_target = w_btb_taken ? w_btb_target : pc_plus;

  // A wrong direction, or a right "taken" with the wrong target, is a mispredict.
  assign w_mis = ex_valid &&
                 ((ex_taken != ex_pred_taken) ||
                  (ex_taken && ex_pred_taken && (ex_target != ex_pred_target)));
  assign flush = w_mis;

  assign w_redirect_pc = ex_taken ? ex_target : (ex_pc + STEP);

  // Next fetch address: redirect beats advance, advance beats hold.
  always_comb begin
    // NOTE: default first so every path assigns w_next_pc and no latch is inferred.
    w_next_pc = r_cpc;
    if (w_mis) begin
      w_next_pc = w_redirect_pc;
    end else if (ihit && !halt) begin
      w_next_pc = pred_target;
    end
  end

  // Fetch PC register; reset wins over any redirect or advance.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cpc <= RESET_PC;
    end else begin
      r_cpc <= w_next_pc;
    end
  end

  // Saturating misprediction counter.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_mispred_cnt <= '0;
    end else if (w_mis && (r_mispred_cnt != 32'hFFFF_FFFF)) begin
      r_mispred_cnt <= r_mispred_cnt + 32'd1;
    end
  end

  assign mispred_cnt = r_mispred_cnt;

endmodule

// File: tb/tb_pc_predict.sv
// Self-checking bench for pc_predict: a table-level BTB model checked on every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_pc_predict;

  localparam int N     = 16;
  localparam int IDX_W = 4;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        ihit = 1'b0;
  logic        halt = 1'b0;
  logic        ex_valid = 1'b0;
  logic [31:0] ex_pc = '0;
  logic        ex_taken = 1'b0;
  logic [31:0] ex_target = '0;
  logic        ex_pred_taken = 1'b0;
  logic [31:0] ex_pred_target = '0;
  logic [31:0] cpc, pc_plus, pred_target, mispred_cnt;
  logic        pred_taken, flush;

  pc_predict #(
    .WORD_W      (32),
    .BTB_ENTRIES (N),
    .RESET_PC    (32'h0),
    .CNT_INIT    (2'b10)
  ) dut (
    .CLK            (CLK),
    .RST            (RST),
    .ihit           (ihit),
    .halt           (halt),
    .ex_valid       (ex_valid),
    .ex_pc          (ex_pc),
    .ex_taken       (ex_taken),
    .ex_target      (ex_target),
    .ex_pred_taken  (ex_pred_taken),
    .ex_pred_target (ex_pred_target),
    .cpc            (cpc),
    .pc_plus        (pc_plus),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .flush          (flush),
    .mispred_cnt    (mispred_cnt)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_valid [N];
  logic [31:0] m_tag   [N];
  logic [31:0] m_tgt   [N];
  int          m_cnt   [N];
  logic [31:0] m_cpc;
  logic [31:0] m_mcnt;

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % N);
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] pc);
    return pc >> (IDX_W + 2);
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return m_valid[idx_of(pc)] && (m_tag[idx_of(pc)] == tag_of(pc));
  endfunction

  function automatic bit m_ptaken(input logic [31:0] pc);
    return m_hit(pc) && (m_cnt[idx_of(pc)] >= 2);
  endfunction

  function automatic logic [31:0] m_ptarget(input logic [31:0] pc);
    return m_ptaken(pc) ? m_tgt[idx_of(pc)] : pc + 32'd4;
  endfunction

  function automatic bit m_mis();
    if (!ex_valid) return 1'b0;
    if (ex_taken != ex_pred_taken) return 1'b1;
    return ex_taken && (ex_target != ex_pred_target);
  endfunction

  // Advance the model by one clock edge from the inputs present at that edge.
  always @(posedge CLK) begin
    if (RST) begin
      m_cpc  = 32'h0;
      m_mcnt = 32'h0;
      for (int i = 0; i < N; i++) begin
        m_valid[i] = 1'b0;
        m_cnt[i]   = 1;
      end
    end else begin
      automatic bit mis = m_mis();
      automatic int ix  = idx_of(ex_pc);
      if (mis) begin
        m_cpc = ex_taken ? ex_target : ex_pc + 32'd4;
        if (m_mcnt != 32'hFFFF_FFFF) m_mcnt = m_mcnt + 1;
      end else if (ihit && !halt) begin
        m_cpc = m_ptarget(m_cpc);
      end
      if (ex_valid) begin
        if (m_hit(ex_pc)) begin
          if (ex_taken) begin
            m_cnt[ix] = (m_cnt[ix] == 3) ? 3 : m_cnt[ix] + 1;
            m_tgt[ix] = ex_target;
          end else begin
            m_cnt[ix] = (m_cnt[ix] == 0) ? 0 : m_cnt[ix] - 1;
          end
        end else if (ex_taken) begin
          m_valid[ix] = 1'b1;
          m_tag[ix]   = tag_of(ex_pc);
          m_tgt[ix]   = ex_target;
          m_cnt[ix]   = 2;
        end
      end
    end
  end

  // Compare every output against the model mid-cycle.
  always @(negedge CLK) begin
    if (chk_en) begin
      check("cpc",         cpc,                m_cpc);
      check("pc_plus",     pc_plus,            m_cpc + 32'd4);
      check("pred_taken",  32'(pred_taken),    32'(m_ptaken(m_cpc)));
      check("pred_target", pred_target,        m_ptarget(m_cpc));
      check("flush",       32'(flush),         32'(m_mis()));
      check("mispred_cnt", mispred_cnt,        m_mcnt);
    end
  end

  // ---------------- stimulus ----------------
  task automatic apply(input logic rst, input logic ih, input logic hl, input logic ev,
                       input logic [31:0] epc, input logic et, input logic [31:0] etgt,
                       input logic ept, input logic [31:0] eptgt);
    @(posedge CLK);
    #1;
    RST = rst; ihit = ih; halt = hl; ex_valid = ev; ex_pc = epc;
    ex_taken = et; ex_target = etgt; ex_pred_taken = ept; ex_pred_target = eptgt;
    @(negedge CLK);
  endtask

  task automatic idle(input logic ih);
    apply(1'b0, ih, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  // Force fetch to addr via a not-taken resolution at addr-4 that was predicted taken.
  task automatic redir(input logic [31:0] addr);
    apply(1'b0, 1'b0, 1'b0, 1'b1, addr - 32'd4, 1'b0, 32'h0, 1'b1, addr);
  endtask

  initial begin
    apply(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk_en = 1'b1;
    apply(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);

    // Sequential fetch after reset.
    idle(1'b1);
    check("rst_cpc", cpc, 32'h0);
    check("rst_pred_taken", 32'(pred_taken), 32'h0);
    check("rst_pred_target", pred_target, 32'h4);
    check("rst_mispred", mispred_cnt, 32'h0);
    idle(1'b1); check("seq_cpc4", cpc, 32'h4);
    idle(1'b1); check("seq_cpc8", cpc, 32'h8);
    idle(1'b1); check("seq_cpc12", cpc, 32'hC);

    // Taken branch at 0x10 -> 0x40, predicted not taken.
    apply(1'b0, 1'b0, 1'b0, 1'b1, 32'h10, 1'b1, 32'h40, 1'b0, 32'h14);
    check("br_cpc", cpc, 32'h10);
    check("br_flush", 32'(flush), 32'h1);
    idle(1'b0);
    check("br_redirect", cpc, 32'h40);
    check("br_mispred", mispred_cnt, 32'h1);
    redir(32'h10);
    idle(1'b0);
    check("learn_pred_taken", 32'(pred_taken), 32'h1);
    check("learn_pred_target", pred_target, 32'h40);

    // Two not-taken resolutions: 10 -> 01 -> 00.
    apply(1'b0, 1'b0, 1'b0, 1'b1, 32'h10, 1'b0, 32'h0, 1'b1, 32'h40);
    check("nt1_flush", 32'(flush), 32'h1);
    apply(1'b0, 1'b0, 1'b0, 1'b1, 32'h10, 1'b0, 32'h0, 1'b1, 32'h40);
    check("nt2_cpc", cpc, 32'h14);
    redir(32'h10);
    check("nt2_redirect", cpc, 32'h14);
    idle(1'b0);
    check("decay_pred_taken", 32'(pred_taken), 32'h0);
    check("decay_pred_target", pred_target, 32'h14);
    check("decay_mispred", mispred_cnt, 32'h5);

    // Alias 0x50 onto the same index.
    apply(1'b0, 1'b0, 1'b0, 1'b1, 32'h50, 1'b1, 32'h60, 1'b0, 32'h54);
    redir(32'h10);
    check("alias_redirect", cpc, 32'h60);
    idle(1'b0);
    check("alias_miss_taken", 32'(pred_taken), 32'h0);
    check("alias_miss_target", pred_target, 32'h14);
    redir(32'h50);
    idle(1'b0);
    check("alias_new_taken", 32'(pred_taken), 32'h1);
    check("alias_new_target", pred_target, 32'h60);

    // Indirect target change at 0x20: 0x80 then 0x90.
    apply(1'b0, 1'b0, 1'b0, 1'b1, 32'h20, 1'b1, 32'h80, 1'b0, 32'h24);
    apply(1'b0, 1'b0, 1'b0, 1'b1, 32'h20, 1'b1, 32'h90, 1'b1, 32'h80);
    check("jr_cpc", cpc, 32'h80);
    check("jr_flush", 32'(flush), 32'h1);
    redir(32'h20);
    check("jr_redirect", cpc, 32'h90);
    idle(1'b0);
    check("jr_new_target", pred_target, 32'h90);

    // Redirect while halted, then hold under halt.
    apply(1'b0, 1'b0, 1'b1, 1'b1, 32'h30, 1'b1, 32'h100, 1'b0, 32'h34);
    check("halt_flush", 32'(flush), 32'h1);
    apply(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    check("halt_redirect", cpc, 32'h100);
    apply(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    check("halt_hold", cpc, 32'h100);

    // PC wrap at the top of the address space.
    redir(32'hFFFF_FFFC);
    idle(1'b1);
    check("wrap_cpc", cpc, 32'hFFFF_FFFC);
    check("wrap_pc_plus", pc_plus, 32'h0);
    idle(1'b0);
    check("wrap_next", cpc, 32'h0);

    // Reset on the same edge as a redirect.
    apply(1'b1, 1'b1, 1'b0, 1'b1, 32'h30, 1'b1, 32'h200, 1'b0, 32'h34);
    idle(1'b0);
    check("rst_over_cpc", cpc, 32'h0);
    check("rst_over_mispred", mispred_cnt, 32'h0);

    // Random traffic over a small address pool to provoke hits and aliasing.
    for (int c = 0; c < 1500; c++) begin
      automatic logic [31:0] pool [6] = '{32'h10, 32'h20, 32'h50, 32'h90, 32'h110, 32'h24};
      automatic logic [31:0] epc  = pool[$urandom_range(0, 5)];
      automatic logic [31:0] etgt = ($urandom_range(0, 1) == 1) ? pool[$urandom_range(0, 5)]
                                                                : ($urandom & 32'hFFFF_FFFC);
      automatic logic et  = 1'($urandom_range(0, 1));
      automatic bit   use_m = ($urandom_range(0, 1) == 1);
      automatic logic ept = use_m ? m_ptaken(epc) : 1'($urandom_range(0, 1));
      automatic logic [31:0] eptgt = use_m ? m_ptarget(epc) : pool[$urandom_range(0, 5)];
      apply(1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 4) < 2),
            epc, et, etgt, ept, eptgt);
    end

    @(posedge CLK);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
